// File: rtl/i2cmb_wb_sequencer.sv
// ---------------------------------------------------------------------------
// i2cmb_wb_sequencer
//
// Wishbone master placed in front of the I2C multi-bus controller's register
// port. One request (single-byte read or write) is expanded into the
// controller's command sequence: Set Bus, Start, address, data, Stop. After
// each command the sequencer waits for the controller interrupt, reads CMDR
// to learn the outcome and decides how to continue.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_read, req_bus, req_addr, req_wdata   request fields
//   rsp_valid             one-cycle completion pulse
//   rsp_status            0 OK, 1 NAK, 2 ARB_LOST, 3 ERR, 4 TIMEOUT, 5 BAD_BUS
//   rsp_rdata             byte read (0x00 unless a read completed OK)
//   cyc_o, stb_o, we_o, adr_o, dat_o, dat_i, ack_i   Wishbone master port
//   irq_i                 controller interrupt (level)
// ---------------------------------------------------------------------------
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_read,
    input  logic [7:0]               req_bus,
    input  logic [6:0]               req_addr,
    input  logic [7:0]               req_wdata,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_status,
    output logic [7:0]               rsp_rdata,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_NAK      = 3'd1;
    localparam logic [2:0] ST_ARB_LOST = 3'd2;
    localparam logic [2:0] ST_ERR      = 3'd3;
    localparam logic [2:0] ST_TIMEOUT  = 3'd4;
    localparam logic [2:0] ST_BAD_BUS  = 3'd5;

    localparam logic [8:0]    NUM_BUS_L   = 9'(NUM_I2C_BUSSES);
    localparam logic [TW-1:0] TIMEOUT_L   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_ENABLE, S_BUS, S_START, S_ADDR, S_DATA, S_STOP,
        S_WAIT_IRQ, S_READ_CMDR, S_READ_DPR, S_RESP
    } state_t;

    state_t                   r_state, r_state_next;
    state_t                   r_step, r_step_next;      // command awaiting its irq
    logic                     r_phase, r_phase_next;    // 1 = DPR already written
    logic                     r_enabled, r_enabled_next;
    logic                     r_ready, r_ready_next;
    logic                     r_cyc, r_cyc_next;
    logic                     r_we, r_we_next;
    logic [WB_ADDR_WIDTH-1:0] r_adr, r_adr_next;
    logic [WB_DATA_WIDTH-1:0] r_dat, r_dat_next;
    logic [TW-1:0]            r_timer, r_timer_next;
    logic                     r_read, r_read_next;
    logic [7:0]               r_bus, r_bus_next;
    logic [6:0]               r_addr, r_addr_next;
    logic [7:0]               r_wdata, r_wdata_next;
    logic                     r_nak, r_nak_next;
    logic [7:0]               r_rx, r_rx_next;
    logic [2:0]               r_rsp_status, r_rsp_status_next;
    logic [7:0]               r_rsp_rdata, r_rsp_rdata_next;

    logic                     w_bad_bus;
    logic                     w_need_dpr;
    logic [7:0]               w_dpr_val;
    logic [7:0]               w_cmd;
    logic [TW-1:0]            w_timer_inc;

    assign w_bad_bus   = ({1'b0, req_bus} >= NUM_BUS_L);
    assign w_timer_inc = (r_timer == TIMEOUT_L) ? r_timer : r_timer + 1'b1;

    // Per-step register contents: optional DPR payload, then the CMDR opcode.
    always_comb begin
        w_need_dpr = 1'b0;
        w_dpr_val  = 8'h00;
        w_cmd      = 8'h00;
        case (r_state)
            S_BUS:   begin w_need_dpr = 1'b1; w_dpr_val = r_bus; w_cmd = 8'h06; end
            S_START: begin w_cmd = 8'h04; end
            S_ADDR:  begin w_need_dpr = 1'b1; w_dpr_val = {r_addr, r_read}; w_cmd = 8'h01; end
            S_DATA:  begin
                w_need_dpr = !r_read;
                w_dpr_val  = r_wdata;
                w_cmd      = r_read ? 8'h03 : 8'h01;
            end
            S_STOP:  begin w_cmd = 8'h05; end
            default: begin end
        endcase
    end

    always_comb begin
        r_state_next      = r_state;
        r_step_next       = r_step;
        r_phase_next      = r_phase;
        r_enabled_next    = r_enabled;
        r_cyc_next        = r_cyc;
        r_we_next         = r_we;
        r_adr_next        = r_adr;
        r_dat_next        = r_dat;
        r_timer_next      = r_timer;
        r_read_next       = r_read;
        r_bus_next        = r_bus;
        r_addr_next       = r_addr;
        r_wdata_next      = r_wdata;
        r_nak_next        = r_nak;
        r_rx_next         = r_rx;
        r_rsp_status_next = r_rsp_status;
        r_rsp_rdata_next  = r_rsp_rdata;

        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    r_read_next  = req_read;
                    r_bus_next   = req_bus;
                    r_addr_next  = req_addr;
                    r_wdata_next = req_wdata;
                    r_nak_next   = 1'b0;
                    r_rx_next    = 8'h00;
                    if (w_bad_bus) begin
                        r_state_next      = S_RESP;
                        r_rsp_status_next = ST_BAD_BUS;
                        r_rsp_rdata_next  = 8'h00;
                    end else if (!r_enabled) begin
                        r_state_next = S_ENABLE;
                    end else begin
                        r_state_next = S_BUS;
                    end
                end
            end

            S_ENABLE: begin
                if (!r_cyc) begin
                    r_cyc_next = 1'b1;
                    r_we_next  = 1'b1;
                    r_adr_next = ADR_CSR;
                    r_dat_next = WB_DATA_WIDTH'(8'hC0);
                end else if (ack_i) begin
                    r_cyc_next     = 1'b0;
                    r_we_next      = 1'b0;
                    r_enabled_next = 1'b1;
                    r_state_next   = S_BUS;
                end
            end

            S_BUS, S_START, S_ADDR, S_DATA, S_STOP: begin
                // A new transfer only launches while cyc is low, so the
                // cycle after every ack is always an idle bus cycle.
                if (!r_cyc) begin
                    r_cyc_next = 1'b1;
                    r_we_next  = 1'b1;
                    if (!r_phase && w_need_dpr) begin
                        r_adr_next = ADR_DPR;
                        r_dat_next = WB_DATA_WIDTH'(w_dpr_val);
                    end else begin
                        r_adr_next = ADR_CMDR;
                        r_dat_next = WB_DATA_WIDTH'(w_cmd);
                    end
                end else if (ack_i) begin
                    r_cyc_next = 1'b0;
                    r_we_next  = 1'b0;
                    if (!r_phase && w_need_dpr) begin
                        r_phase_next = 1'b1;
                    end else begin
                        r_phase_next = 1'b0;
                        r_step_next  = r_state;
                        r_timer_next = '0;
                        r_state_next = S_WAIT_IRQ;
                    end
                end
            end

            S_WAIT_IRQ: begin
                if (irq_i) begin
                    r_state_next = S_READ_CMDR;
                end else if (w_timer_inc == TIMEOUT_L) begin
                    // Controller state is unknown now; force a CSR rewrite.
                    r_state_next      = S_RESP;
                    r_rsp_status_next = ST_TIMEOUT;
                    r_rsp_rdata_next  = 8'h00;
                    r_enabled_next    = 1'b0;
                end else begin
                    r_timer_next = w_timer_inc;
                end
            end

            S_READ_CMDR: begin
                if (!r_cyc) begin
                    r_cyc_next = 1'b1;
                    r_we_next  = 1'b0;
                    r_adr_next = ADR_CMDR;
                end else if (ack_i) begin
                    r_cyc_next = 1'b0;
                    if (dat_i[5]) begin
                        r_state_next      = S_RESP;
                        r_rsp_status_next = ST_ARB_LOST;
                        r_rsp_rdata_next  = 8'h00;
                    end else if (dat_i[4]) begin
                        r_state_next      = S_RESP;
                        r_rsp_status_next = ST_ERR;
                        r_rsp_rdata_next  = 8'h00;
                    end else if (dat_i[6] && (r_step == S_ADDR ||
                                              (r_step == S_DATA && !r_read))) begin
                        // Slave refused: release the bus, report NAK afterwards.
                        r_nak_next   = 1'b1;
                        r_state_next = S_STOP;
                    end else if (dat_i[7]) begin
                        case (r_step)
                            S_BUS:   r_state_next = S_START;
                            S_START: r_state_next = S_ADDR;
                            S_ADDR:  r_state_next = S_DATA;
                            S_DATA:  r_state_next = r_read ? S_READ_DPR : S_STOP;
                            default: begin
                                r_state_next      = S_RESP;
                                r_rsp_status_next = r_nak ? ST_NAK : ST_OK;
                                r_rsp_rdata_next  = (!r_nak && r_read) ? r_rx : 8'h00;
                            end
                        endcase
                    end else begin
                        r_state_next      = S_RESP;
                        r_rsp_status_next = ST_ERR;
                        r_rsp_rdata_next  = 8'h00;
                    end
                end
            end

            S_READ_DPR: begin
                if (!r_cyc) begin
                    r_cyc_next = 1'b1;
                    r_we_next  = 1'b0;
                    r_adr_next = ADR_DPR;
                end else if (ack_i) begin
                    r_cyc_next   = 1'b0;
                    r_rx_next    = dat_i[7:0];
                    r_state_next = S_STOP;
                end
            end

            S_RESP: begin
                r_state_next = S_IDLE;
            end

            default: begin
                r_state_next = S_IDLE;
            end
        endcase

        r_ready_next = (r_state_next == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_step       <= S_IDLE;
            r_phase      <= 1'b0;
            r_enabled    <= 1'b0;
            r_ready      <= 1'b0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_timer      <= '0;
            r_read       <= 1'b0;
            r_bus        <= 8'h00;
            r_addr       <= 7'h00;
            r_wdata      <= 8'h00;
            r_nak        <= 1'b0;
            r_rx         <= 8'h00;
            r_rsp_status <= 3'd0;
            r_rsp_rdata  <= 8'h00;
        end else begin
            r_state      <= r_state_next;
            r_step       <= r_step_next;
            r_phase      <= r_phase_next;
            r_enabled    <= r_enabled_next;
            r_ready      <= r_ready_next;
            r_cyc        <= r_cyc_next;
            r_we         <= r_we_next;
            r_adr        <= r_adr_next;
            r_dat        <= r_dat_next;
            r_timer      <= r_timer_next;
            r_read       <= r_read_next;
            r_bus        <= r_bus_next;
            r_addr       <= r_addr_next;
            r_wdata      <= r_wdata_next;
            r_nak        <= r_nak_next;
            r_rx         <= r_rx_next;
            r_rsp_status <= r_rsp_status_next;
            r_rsp_rdata  <= r_rsp_rdata_next;
        end
    end

    assign req_ready  = r_ready;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_status = r_rsp_status;
    assign rsp_rdata  = r_rsp_rdata;
    assign cyc_o      = r_cyc;
    assign stb_o      = r_cyc;
    assign we_o       = r_we;
    assign adr_o      = r_adr;
    assign dat_o      = r_dat;

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// ---------------------------------------------------------------------------
// Directed bench for i2cmb_wb_sequencer. A small behavioural model of the
// controller's register port acks every access in its first cycle, raises
// irq after each CMDR write and answers CMDR reads with a scenario-selected
// status byte. Every Wishbone write is logged and compared with a
// hand-written expected list.
// ---------------------------------------------------------------------------
module tb_i2cmb_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_read = 1'b0;
    logic [7:0] req_bus = 8'h00;
    logic [6:0] req_addr = 7'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [2:0] rsp_status;
    logic [7:0] rsp_rdata;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       irq_i = 1'b0;

    // slave model controls
    logic       ack_hold = 1'b0;
    logic       irq_suppress = 1'b0;
    logic       nak_mode = 1'b0;
    logic       al_mode = 1'b0;
    logic       after_start = 1'b0;
    logic [7:0] cmdr_status = 8'h80;
    logic [7:0] rd_byte = 8'h00;

    int cyc_cnt = 0;
    int wb_count = 0;
    int rsp_count = 0;
    int last_wr_cyc = 0;
    logic [1:0] log_adr[$];
    logic [7:0] log_dat[$];
    logic [1:0] exp_adr[$];
    logic [7:0] exp_dat[$];

    int checks = 0;
    int errors = 0;
    int txn = 0;
    logic [2:0] got_status;
    logic [7:0] got_rdata;
    int got_lat;

    i2cmb_wb_sequencer #(
        .WB_ADDR_WIDTH (2),
        .WB_DATA_WIDTH (8),
        .NUM_I2C_BUSSES(1),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_read  (req_read),
        .req_bus   (req_bus),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_status(rsp_status),
        .rsp_rdata (rsp_rdata),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .irq_i     (irq_i)
    );

    always #5 clk = ~clk;

    assign ack_i = cyc_o & stb_o & ~ack_hold;
    assign dat_i = (adr_o == 2'd2) ? cmdr_status :
                   (adr_o == 2'd1) ? rd_byte : 8'h00;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rsp_valid) rsp_count <= rsp_count + 1;
        if (rst_i) begin
            irq_i <= 1'b0;
        end else if (cyc_o && stb_o && ack_i) begin
            wb_count <= wb_count + 1;
            if (we_o) begin
                log_adr.push_back(adr_o);
                log_dat.push_back(dat_o);
                last_wr_cyc <= cyc_cnt;
                if (adr_o == 2'd2) begin
                    if (!irq_suppress) irq_i <= 1'b1;
                    if (dat_o == 8'h04) after_start <= 1'b1;
                    if (dat_o == 8'h01) after_start <= 1'b0;
                    if (al_mode && dat_o == 8'h04)
                        cmdr_status <= 8'h20;
                    else if (nak_mode && dat_o == 8'h01 && after_start)
                        cmdr_status <= 8'h40;
                    else
                        cmdr_status <= 8'h80;
                end
            end else if (adr_o == 2'd2) begin
                irq_i <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_clear();
        exp_adr.delete();
        exp_dat.delete();
    endtask

    task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
        exp_adr.push_back(a);
        exp_dat.push_back(d);
    endtask

    task automatic check_log(input string tag);
        int n;
        chk($sformatf("%s_nwrites", tag), 32'(log_adr.size()), 32'(exp_adr.size()));
        n = (log_adr.size() < exp_adr.size()) ? log_adr.size() : exp_adr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_adr%0d", tag, i), 32'(log_adr[i]), 32'(exp_adr[i]));
            chk($sformatf("%s_dat%0d", tag, i), 32'(log_dat[i]), 32'(exp_dat[i]));
        end
    endtask

    task automatic do_req(input logic rd, input logic [7:0] bus,
                          input logic [6:0] addr, input logic [7:0] wd);
        int n;
        log_adr.delete();
        log_dat.delete();
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_before", 32'(req_ready), 1);
        @(negedge clk);
        req_read  = rd;
        req_bus   = bus;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 2000) begin
            chk("req_ready_busy", 32'(req_ready), 0);
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_seen", 32'(rsp_valid), 1);
        got_status = rsp_status;
        got_rdata  = rsp_rdata;
        got_lat    = (cyc_cnt - 1) - last_wr_cyc;
        @(posedge clk); #1;
        chk("rsp_one_cycle", 32'(rsp_valid), 0);
        chk("rsp_status_hold", 32'(rsp_status), 32'(got_status));
        chk("req_ready_after", 32'(req_ready), 1);
        txn++;
        $display("txn %0d: %s bus=%0d addr=0x%02h wdata=0x%02h -> status=%0d rdata=0x%02h writes=%0d",
                 txn, rd ? "read " : "write", bus, addr, wd, got_status, got_rdata, log_adr.size());
    endtask

    task automatic exp_full_write(input logic csr, input logic [6:0] a, input logic [7:0] d);
        exp_clear();
        if (csr) exp_w(2'd0, 8'hC0);
        exp_w(2'd1, 8'h00); exp_w(2'd2, 8'h06);
        exp_w(2'd2, 8'h04);
        exp_w(2'd1, {a, 1'b0}); exp_w(2'd2, 8'h01);
        exp_w(2'd1, d); exp_w(2'd2, 8'h01);
        exp_w(2'd2, 8'h05);
    endtask

    initial begin
        int snap;
        int stops;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_cyc", 32'(cyc_o), 0);
        chk("rst_stb", 32'(stb_o), 0);
        chk("rst_we", 32'(we_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_adr", 32'(adr_o), 0);
        chk("rst_dat", 32'(dat_o), 0);
        chk("rst_status", 32'(rsp_status), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(req_ready), 1);

        // ---- write after reset: full sequence including CSR enable
        exp_full_write(1'b1, 7'h22, 8'h5A);
        do_req(1'b0, 8'd0, 7'h22, 8'h5A);
        check_log("wr1");
        chk("wr1_status", 32'(got_status), 0);
        chk("wr1_rdata", 32'(got_rdata), 0);

        // ---- read, slave returns 0xA5, no CSR rewrite
        rd_byte = 8'hA5;
        exp_clear();
        exp_w(2'd1, 8'h00); exp_w(2'd2, 8'h06);
        exp_w(2'd2, 8'h04);
        exp_w(2'd1, 8'h45); exp_w(2'd2, 8'h01);
        exp_w(2'd2, 8'h03);
        exp_w(2'd2, 8'h05);
        snap = wb_count;
        do_req(1'b1, 8'd0, 7'h22, 8'h00);
        check_log("rd1");
        chk("rd1_status", 32'(got_status), 0);
        chk("rd1_rdata", 32'(got_rdata), 32'h A5);
        chk("rd1_reads", 32'((wb_count - snap) - log_adr.size()), 6);

        // ---- address NAK on a read: Stop still issued, rdata forced to 0
        nak_mode = 1'b1;
        exp_clear();
        exp_w(2'd1, 8'h00); exp_w(2'd2, 8'h06);
        exp_w(2'd2, 8'h04);
        exp_w(2'd1, 8'h23); exp_w(2'd2, 8'h01);
        exp_w(2'd2, 8'h05);
        do_req(1'b1, 8'd0, 7'h11, 8'h00);
        check_log("nak");
        chk("nak_status", 32'(got_status), 1);
        chk("nak_rdata", 32'(got_rdata), 0);
        nak_mode = 1'b0;

        // ---- bad bus: no Wishbone traffic at all
        exp_clear();
        snap = wb_count;
        do_req(1'b0, 8'd3, 7'h22, 8'h11);
        chk("badbus_wb_cycles", 32'(wb_count - snap), 0);
        chk("badbus_status", 32'(got_status), 5);

        // ---- arbitration lost after Start: no Stop written
        al_mode = 1'b1;
        exp_clear();
        exp_w(2'd1, 8'h00); exp_w(2'd2, 8'h06);
        exp_w(2'd2, 8'h04);
        do_req(1'b0, 8'd0, 7'h22, 8'h33);
        check_log("al");
        chk("al_status", 32'(got_status), 2);
        stops = 0;
        for (int i = 0; i < log_adr.size(); i++)
            if (log_adr[i] == 2'd2 && log_dat[i] == 8'h05) stops++;
        chk("al_no_stop", 32'(stops), 0);
        al_mode = 1'b0;

        // ---- timeout: irq never arrives
        irq_suppress = 1'b1;
        exp_clear();
        exp_w(2'd1, 8'h00); exp_w(2'd2, 8'h06);
        do_req(1'b0, 8'd0, 7'h22, 8'h44);
        check_log("tmo");
        chk("tmo_status", 32'(got_status), 4);
        chk("tmo_latency", 32'(got_lat), 50);
        irq_suppress = 1'b0;

        // ---- next request re-enables the controller
        exp_full_write(1'b1, 7'h30, 8'hC3);
        do_req(1'b0, 8'd0, 7'h30, 8'hC3);
        check_log("post_tmo");
        chk("post_tmo_status", 32'(got_status), 0);

        // ---- reset while a transfer waits for ack
        ack_hold = 1'b1;
        @(negedge clk);
        req_read = 1'b0; req_bus = 8'd0; req_addr = 7'h22; req_wdata = 8'h77;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        snap = 0;
        while (!cyc_o && snap < 20) begin
            @(posedge clk); #1;
            snap++;
        end
        chk("stall_cyc_high", 32'(cyc_o), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        snap = rsp_count;
        @(posedge clk); #1;
        chk("mid_rst_cyc", 32'(cyc_o), 0);
        chk("mid_rst_stb", 32'(stb_o), 0);
        chk("mid_rst_we", 32'(we_o), 0);
        chk("mid_rst_adr", 32'(adr_o), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_i = 1'b0;
        ack_hold = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_rsp", 32'(rsp_count - snap), 0);

        exp_full_write(1'b1, 7'h22, 8'h77);
        do_req(1'b0, 8'd0, 7'h22, 8'h77);
        check_log("post_rst");
        chk("post_rst_status", 32'(got_status), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
